// File: rtl/pcihellocore_pio_pkg.sv
// Shared register map and edge-type encodings for the PIO input/output port blocks.
// Latency: none (constants and a combinational helper only).
// Backpressure: none; the Avalon slave bus has no wait states.
package pcihellocore_pio_pkg;

    // Slave register map, common to the output ports and the host driver header
    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RSVD    = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    // Edge selection for the capture register
    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

    // A bus write is a selected cycle with the active-low write strobe asserted
    function automatic logic pio_wr_strobe(input logic chipselect, input logic write_n);
        return chipselect && !write_n;
    endfunction

endpackage

// File: rtl/pcihellocore_swinport_if.sv
// Avalon-MM slave bus bundle shared by the host bridge and the PIO input port.
// Latency: readdata is registered in the slave, valid one cycle after address.
// Backpressure: none; the slave accepts every cycle (no waitrequest).
interface pcihellocore_swinport_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );

endinterface

// File: rtl/pcihellocore_debounce.sv
// Synchronizes asynchronous input lines and accepts a level once stable over two sample ticks.
// Latency: bypass 3 cycles (2 sync + 1 output register); debounced 2-3 tick periods after sync.
// Backpressure: none; free-running, one sample path per input bit.
module pcihellocore_debounce #(
    parameter int WIDTH           = 32,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_port_i,
    output logic [WIDTH-1:0] debounced_o
);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] debounced_q;
    logic [WIDTH-1:0] debounced_d;

    // Two-flop synchronizer; nothing else in the block looks at the raw pins
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= in_port_i;
            sync2_q <= sync1_q;
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass

            // No filtering: the debounced register simply follows the synchronizer
            always_comb begin
                debounced_d = sync2_q;
            end

        end else begin : g_filter

            localparam int              CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

            logic [CNT_W-1:0] count_q;
            logic [CNT_W-1:0] count_d;
            logic             tick;
            logic [WIDTH-1:0] stage_a_q;
            logic [WIDTH-1:0] stage_a_d;
            logic [WIDTH-1:0] stage_b_q;
            logic [WIDTH-1:0] stage_b_d;
            logic [WIDTH-1:0] agree;

            // Sample-tick counter wraps at DEBOUNCE_CYCLES-1; tick marks the wrap cycle
            always_comb begin
                tick    = (count_q == CNT_LAST);
                count_d = tick ? '0 : count_q + CNT_W'(1);
            end

            // Two-deep sample history; a bit is accepted only where both samples agree
            always_comb begin
                stage_a_d   = stage_a_q;
                stage_b_d   = stage_b_q;
                debounced_d = debounced_q;
                agree       = ~(stage_a_q ^ stage_b_q);
                if (tick) begin
                    stage_a_d   = sync2_q;
                    stage_b_d   = stage_a_q;
                    debounced_d = (agree & stage_a_q) | (~agree & debounced_q);
                end
            end

            // Counter and sample stages restart from zero on every reset
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    count_q   <= '0;
                    stage_a_q <= '0;
                    stage_b_q <= '0;
                end else begin
                    count_q   <= count_d;
                    stage_a_q <= stage_a_d;
                    stage_b_q <= stage_b_d;
                end
            end

        end
    endgenerate

    // Accepted input level, shared by both filtering modes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            debounced_q <= '0;
        end else begin
            debounced_q <= debounced_d;
        end
    end

    assign debounced_o = debounced_q;

endmodule

// File: rtl/pcihellocore_swinport.sv
// Avalon-MM switch/button input port: debounce, edge capture, maskable level IRQ.
// Latency: readdata 1 cycle after address; edge flag 1 cycle after debounced, irq 1 cycle later.
// Backpressure: none; slave never stalls, reads are side-effect free.
module pcihellocore_swinport
    import pcihellocore_pio_pkg::*;
#(
    parameter int               WIDTH           = 32,
    parameter int               DEBOUNCE_CYCLES = 50000,
    parameter int               EDGE_TYPE       = EDGE_RISING,
    parameter logic [WIDTH-1:0] RESET_MASK      = '0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    pcihellocore_swinport_if.slave bus,
    input  logic [WIDTH-1:0]       in_port,
    output logic                   irq
);

    logic [WIDTH-1:0] debounced;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_event;

    logic             wr_en;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] clear_mask;

    logic [WIDTH-1:0] irqmask_q;
    logic [WIDTH-1:0] irqmask_d;
    logic [WIDTH-1:0] edgecap_q;
    logic [WIDTH-1:0] edgecap_d;
    logic             irq_q;
    logic             irq_d;
    logic [31:0]      readdata_q;
    logic [31:0]      readdata_d;

    pcihellocore_debounce #(
        .WIDTH           (WIDTH),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_port_i   (in_port),
        .debounced_o (debounced)
    );

    // Edge selection from the current and previous debounced levels
    always_comb begin
        rise = debounced & ~prev_q;
        fall = ~debounced & prev_q;
        case (EDGE_TYPE)
            EDGE_RISING:  edge_event = rise;
            EDGE_FALLING: edge_event = fall;
            EDGE_ANY:     edge_event = rise | fall;
            default:      edge_event = rise | fall;
        endcase
    end

    // Register writes; bits of writedata above WIDTH have no destination
    always_comb begin
        wr_en      = pio_wr_strobe(bus.chipselect, bus.write_n);
        wdata      = bus.writedata[WIDTH-1:0];
        irqmask_d  = irqmask_q;
        clear_mask = '0;
        if (wr_en && (bus.address == ADDR_IRQMASK)) begin
            irqmask_d = wdata;
        end
        if (wr_en && (bus.address == ADDR_EDGECAP)) begin
            clear_mask = wdata;
        end
        // A new edge in the clearing cycle must not be lost, so the event is OR-ed in last
        edgecap_d = (edgecap_q & ~clear_mask) | edge_event;
        irq_d     = |(edgecap_q & irqmask_q);
    end

    // Read mux samples pre-write register values, so a clearing read sees the old flags
    always_comb begin
        readdata_d = '0;
        case (bus.address)
            ADDR_DATA:    readdata_d[WIDTH-1:0] = debounced;
            ADDR_RSVD:    readdata_d = '0;
            ADDR_IRQMASK: readdata_d[WIDTH-1:0] = irqmask_q;
            ADDR_EDGECAP: readdata_d[WIDTH-1:0] = edgecap_q;
            default:      readdata_d = '0;
        endcase
    end

    // Edge history, control/status registers, registered read data and interrupt
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q     <= '0;
            irqmask_q  <= RESET_MASK;
            edgecap_q  <= '0;
            irq_q      <= 1'b0;
            readdata_q <= '0;
        end else begin
            prev_q     <= debounced;
            irqmask_q  <= irqmask_d;
            edgecap_q  <= edgecap_d;
            irq_q      <= irq_d;
            readdata_q <= readdata_d;
        end
    end

    assign bus.readdata = readdata_q;
    assign irq          = irq_q;

endmodule

// File: tb/tb_pcihellocore_swinport.sv
// Directed bench for the PIO input port: bypass, debounced and falling-edge instances.
// Latency: expectations are cycle-exact except the debounce window, which depends on tick phase.
// Backpressure: none on this bus; stimulus drives one access per cycle.
module tb_pcihellocore_swinport;

    logic        clk;
    logic        reset_n;
    logic [31:0] in_byp;
    logic [31:0] in_deb;
    logic [31:0] in_fall;
    logic        irq_byp;
    logic        irq_deb;
    logic        irq_fall;

    int tests;
    int fails;

    pcihellocore_swinport_if bus_byp ();
    pcihellocore_swinport_if bus_deb ();
    pcihellocore_swinport_if bus_fall ();

    pcihellocore_swinport #(
        .WIDTH(32), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(0), .RESET_MASK(32'h0)
    ) u_byp (
        .clk(clk), .reset_n(reset_n), .bus(bus_byp), .in_port(in_byp), .irq(irq_byp)
    );

    pcihellocore_swinport #(
        .WIDTH(32), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0), .RESET_MASK(32'h8)
    ) u_deb (
        .clk(clk), .reset_n(reset_n), .bus(bus_deb), .in_port(in_deb), .irq(irq_deb)
    );

    pcihellocore_swinport #(
        .WIDTH(32), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(1), .RESET_MASK(32'h0)
    ) u_fall (
        .clk(clk), .reset_n(reset_n), .bus(bus_fall), .in_port(in_fall), .irq(irq_fall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bus(input int inst, input logic cs, input logic wn,
                             input logic [1:0] a, input logic [31:0] d);
        case (inst)
            0: begin
                bus_byp.chipselect = cs; bus_byp.write_n = wn;
                bus_byp.address = a;     bus_byp.writedata = d;
            end
            1: begin
                bus_deb.chipselect = cs; bus_deb.write_n = wn;
                bus_deb.address = a;     bus_deb.writedata = d;
            end
            default: begin
                bus_fall.chipselect = cs; bus_fall.write_n = wn;
                bus_fall.address = a;     bus_fall.writedata = d;
            end
        endcase
    endtask

    task automatic bus_wr(input int inst, input logic [1:0] a, input logic [31:0] d);
        drive_bus(inst, 1'b1, 1'b0, a, d);
        cycles(1);
        drive_bus(inst, 1'b0, 1'b1, a, 32'h0);
    endtask

    task automatic set_addr(input int inst, input logic [1:0] a);
        drive_bus(inst, 1'b0, 1'b1, a, 32'h0);
    endtask

    function automatic logic [31:0] rd(input int inst);
        case (inst)
            0:       return bus_byp.readdata;
            1:       return bus_deb.readdata;
            default: return bus_fall.readdata;
        endcase
    endfunction

    task automatic test_reset();
        logic [31:0] v;
        reset_n = 1'b0;
        in_byp  = 32'hFFFF_FFFF;
        in_deb  = 32'h0;
        in_fall = 32'h0;
        set_addr(0, 2'd0);
        set_addr(1, 2'd0);
        set_addr(2, 2'd0);
        cycles(3);
        tests++; v = rd(0);
        if (v !== 32'h0) begin fails++; $display("FAIL reset_readdata got %h want %h", v, 32'h0); end
        tests++;
        if (irq_byp !== 1'b0) begin fails++; $display("FAIL reset_irq got %b want 0", irq_byp); end
        reset_n = 1'b1;
        cycles(3);
        tests++; v = rd(0);
        if (v !== 32'h0) begin fails++; $display("FAIL rel_data_3cyc got %h want %h", v, 32'h0); end
        cycles(1);
        tests++; v = rd(0);
        if (v !== 32'hFFFF_FFFF) begin fails++; $display("FAIL rel_data_4cyc got %h want %h", v, 32'hFFFF_FFFF); end
        set_addr(0, 2'd3);
        set_addr(1, 2'd2);
        set_addr(2, 2'd2);
        cycles(1);
        tests++; v = rd(0);
        if (v !== 32'hFFFF_FFFF) begin fails++; $display("FAIL rel_edgecap got %h want %h", v, 32'hFFFF_FFFF); end
        tests++;
        if (irq_byp !== 1'b0) begin fails++; $display("FAIL rel_irq_masked got %b want 0", irq_byp); end
        tests++; v = rd(1);
        if (v !== 32'h8) begin fails++; $display("FAIL reset_mask_deb got %h want %h", v, 32'h8); end
        tests++; v = rd(2);
        if (v !== 32'h0) begin fails++; $display("FAIL reset_mask_fall got %h want %h", v, 32'h0); end
        bus_wr(0, 2'd3, 32'hFFFF_FFFF);
        cycles(1);
        tests++; v = rd(0);
        if (v !== 32'h0) begin fails++; $display("FAIL clear_all got %h want %h", v, 32'h0); end
    endtask

    task automatic test_bypass();
        logic [31:0] v;
        bus_wr(0, 2'd2, 32'h1);
        in_byp = 32'h0;
        cycles(5);
        set_addr(0, 2'd3);
        cycles(1);
        in_byp = 32'h1;
        cycles(4);
        tests++; v = rd(0);
        if (v !== 32'h0) begin fails++; $display("FAIL byp_cap_early got %h want %h", v, 32'h0); end
        tests++;
        if (irq_byp !== 1'b0) begin fails++; $display("FAIL byp_irq_early got %b want 0", irq_byp); end
        cycles(1);
        tests++; v = rd(0);
        if (v !== 32'h1) begin fails++; $display("FAIL byp_cap got %h want %h", v, 32'h1); end
        tests++;
        if (irq_byp !== 1'b1) begin fails++; $display("FAIL byp_irq got %b want 1", irq_byp); end
        bus_wr(0, 2'd3, 32'h1);
        tests++; v = rd(0);
        if (v !== 32'h1) begin fails++; $display("FAIL byp_preclear_read got %h want %h", v, 32'h1); end
        tests++;
        if (irq_byp !== 1'b1) begin fails++; $display("FAIL byp_irq_hold got %b want 1", irq_byp); end
        cycles(1);
        tests++;
        if (irq_byp !== 1'b0) begin fails++; $display("FAIL byp_irq_clear got %b want 0", irq_byp); end
        set_addr(0, 2'd0);
        cycles(1);
        tests++; v = rd(0);
        if (v !== 32'h1) begin fails++; $display("FAIL byp_data got %h want %h", v, 32'h1); end
    endtask

    task automatic test_same_cycle_clear();
        logic [31:0] v;
        in_byp = 32'h21;
        cycles(6);
        in_byp = 32'h1;
        cycles(5);
        set_addr(0, 2'd3);
        in_byp = 32'h21;
        cycles(3);
        // This write lands on the same edge that captures the new bit-5 edge
        bus_wr(0, 2'd3, 32'h20);
        tests++; v = rd(0);
        if (v !== 32'h20) begin fails++; $display("FAIL sc_preclear got %h want %h", v, 32'h20); end
        cycles(1);
        tests++; v = rd(0);
        if (v !== 32'h20) begin fails++; $display("FAIL sc_event_wins got %h want %h", v, 32'h20); end
        tests++;
        if (irq_byp !== 1'b0) begin fails++; $display("FAIL sc_irq_masked got %b want 0", irq_byp); end
        bus_wr(0, 2'd3, 32'h20);
        cycles(1);
        tests++; v = rd(0);
        if (v !== 32'h0) begin fails++; $display("FAIL sc_cleared got %h want %h", v, 32'h0); end
    endtask

    task automatic test_reg_map();
        logic [31:0] v;
        bus_wr(0, 2'd0, 32'hDEAD_BEEF);
        bus_wr(0, 2'd1, 32'hDEAD_BEEF);
        set_addr(0, 2'd0);
        cycles(1);
        tests++; v = rd(0);
        if (v !== 32'h21) begin fails++; $display("FAIL map_data got %h want %h", v, 32'h21); end
        set_addr(0, 2'd1);
        cycles(1);
        tests++; v = rd(0);
        if (v !== 32'h0) begin fails++; $display("FAIL map_rsvd got %h want %h", v, 32'h0); end
        set_addr(0, 2'd2);
        cycles(1);
        tests++; v = rd(0);
        if (v !== 32'h1) begin fails++; $display("FAIL map_irqmask got %h want %h", v, 32'h1); end
        set_addr(0, 2'd3);
        cycles(1);
        tests++; v = rd(0);
        if (v !== 32'h0) begin fails++; $display("FAIL map_edgecap got %h want %h", v, 32'h0); end
    endtask

    task automatic test_debounce();
        logic [31:0] v;
        int changed;
        int lat;
        changed = 0;
        lat     = 0;
        set_addr(1, 2'd0);
        cycles(2);
        // Half-period equals the tick period, so consecutive samples always disagree
        for (int t = 0; t < 8; t++) begin
            in_deb[3] = ~in_deb[3];
            for (int c = 0; c < 4; c++) begin
                cycles(1);
                v = rd(1);
                if (v[3] !== 1'b0 || irq_deb !== 1'b0) changed++;
            end
        end
        tests++;
        if (changed !== 0) begin fails++; $display("FAIL deb_toggle_stable got %0d changes want 0", changed); end
        in_deb[3] = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            cycles(1);
            v = rd(1);
            if (v[3] === 1'b1) begin
                lat = i;
                break;
            end
        end
        tests++;
        if (lat < 12 || lat > 15) begin fails++; $display("FAIL deb_accept_latency got %0d want 12..15", lat); end
        cycles(2);
        set_addr(1, 2'd3);
        cycles(1);
        tests++; v = rd(1);
        if (v !== 32'h8) begin fails++; $display("FAIL deb_edgecap got %h want %h", v, 32'h8); end
        tests++;
        if (irq_deb !== 1'b1) begin fails++; $display("FAIL deb_irq got %b want 1", irq_deb); end
    endtask

    task automatic test_falling();
        logic [31:0] v;
        set_addr(2, 2'd3);
        in_fall = 32'h4;
        cycles(6);
        tests++; v = rd(2);
        if (v !== 32'h0) begin fails++; $display("FAIL fall_rise_ignored got %h want %h", v, 32'h0); end
        in_fall = 32'h0;
        cycles(6);
        tests++; v = rd(2);
        if (v !== 32'h4) begin fails++; $display("FAIL fall_captured got %h want %h", v, 32'h4); end
        tests++;
        if (irq_fall !== 1'b0) begin fails++; $display("FAIL fall_irq_masked got %b want 0", irq_fall); end
    endtask

    task automatic test_async_reset();
        logic [31:0] v;
        bus_wr(0, 2'd2, 32'h80);
        in_byp = 32'hA1;
        cycles(6);
        set_addr(0, 2'd3);
        cycles(1);
        tests++; v = rd(0);
        if (v !== 32'h80) begin fails++; $display("FAIL ar_pre_edgecap got %h want %h", v, 32'h80); end
        tests++;
        if (irq_byp !== 1'b1) begin fails++; $display("FAIL ar_pre_irq got %b want 1", irq_byp); end
        in_deb = 32'h0;
        cycles(3);
        // Assert between clock edges to prove the clear does not wait for a clock
        #3;
        reset_n = 1'b0;
        #1;
        tests++; v = rd(0);
        if (v !== 32'h0) begin fails++; $display("FAIL ar_readdata got %h want %h", v, 32'h0); end
        tests++;
        if (irq_byp !== 1'b0) begin fails++; $display("FAIL ar_irq_byp got %b want 0", irq_byp); end
        tests++;
        if (irq_deb !== 1'b0) begin fails++; $display("FAIL ar_irq_deb got %b want 0", irq_deb); end
        cycles(2);
        reset_n = 1'b1;
        set_addr(0, 2'd2);
        set_addr(1, 2'd2);
        cycles(1);
        tests++; v = rd(0);
        if (v !== 32'h0) begin fails++; $display("FAIL ar_mask_byp got %h want %h", v, 32'h0); end
        tests++; v = rd(1);
        if (v !== 32'h8) begin fails++; $display("FAIL ar_mask_deb got %h want %h", v, 32'h8); end
        set_addr(0, 2'd3);
        cycles(4);
        tests++; v = rd(0);
        if (v !== 32'hA1) begin fails++; $display("FAIL ar_recapture got %h want %h", v, 32'hA1); end
        tests++;
        if (irq_byp !== 1'b0) begin fails++; $display("FAIL ar_irq_after got %b want 0", irq_byp); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_bypass();
        test_same_cycle_clear();
        test_reg_map();
        test_debounce();
        test_falling();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "simulation watchdog expired");
    end

endmodule
